// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH+1 edges from start to result.
// Define SERIAL_ADDER_SUB_EN to enable subtract mode (a - b) via the sub port.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one bit per edge through the full-adder cell
// DONE  | single cycle with done high; start here begins the next operation
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    always_comb begin
        bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
        bit_c    = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        accept   = start && ((state == IDLE) || (state == DONE));
        last_bit = (cnt == CW'(WIDTH - 1));
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as a + ~b + 1; cin has no meaning in this mode.
    always_comb begin
        b_load     = sub ? ~b : b;
        carry_load = sub ? 1'b1 : cin;
    end
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                RUN: begin
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= bit_c;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry still holds the carry into the MSB on this edge
                        sum   <= {bit_s, res_sr[WIDTH-1:1]};
                        cout  <= bit_c;
                        ovf   <= carry ^ bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus random operations
// compared with an arithmetic reference model.
module tb_serial_adder;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           edge_n;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } done_t;

    done_t        done_q[$];
    int           edge_cnt = 0;
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] prev_sum = '0;

    // done as a synchronous consumer sees it: value before each rising edge
    always @(posedge clk) begin
        edge_cnt = edge_cnt + 1;
        if (done) done_q.push_back('{edge_cnt, sum, cout, ovf});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci, input logic su);
        int ua, ub, sa, sb, ru, rs;
        logic [W-1:0] s;
        logic c, o;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        ru = ua + ub + int'(ci);
        rs = sa + sb + int'(ci);
        c  = (ru > 255);
`ifdef SERIAL_ADDER_SUB_EN
        if (su) begin
            ru = ua - ub;
            rs = sa - sb;
            c  = (ua >= ub);
        end
`else
        if (su) ru = ru;
`endif
        s = ru[W-1:0];
        o = (rs < -128) || (rs > 127);
        return {o, c, s};
    endfunction

    task automatic wait_done(output done_t d, output bit ok);
        int n = 0;
        while (done_q.size() == 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        ok = (done_q.size() > 0);
        chk("done_seen", 64'(ok), 64'd1);
        if (ok) d = done_q.pop_front();
    endtask

    task automatic check_result(input string tag, input done_t d, input logic [W+1:0] exp);
        chk({tag, "_sum"},  64'(d.s), 64'(exp[W-1:0]));
        chk({tag, "_cout"}, 64'(d.c), 64'(exp[W]));
        chk({tag, "_ovf"},  64'(d.o), 64'(exp[W+1]));
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic su);
        logic [W+1:0] exp;
        done_t        d;
        bit           ok;
        int           acc;
        exp = model(av, bv, ci, su);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = su; start = 1'b1;
        acc = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        repeat (4) @(negedge clk);
        chk({tag, "_hold"}, 64'(sum), 64'(prev_sum));
        wait_done(d, ok);
        if (ok) begin
            chk({tag, "_lat"}, 64'(d.edge_n - acc), 64'(LAT));
            check_result(tag, d, exp);
            chk({tag, "_pulse"}, 64'(done), 64'd0);
            chk({tag, "_held"}, 64'(sum), 64'(exp[W-1:0]));
        end
        prev_sum = exp[W-1:0];
    endtask

    initial begin
        done_t        d1, d2;
        bit           ok1, ok2;
        int           acc;
        logic [W+1:0] e1, e2;

        rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op("d0f01", 8'h0F, 8'h01, 1'b0, 1'b0);
        do_op("dff01", 8'hFF, 8'h01, 1'b0, 1'b0);
        do_op("d7f01", 8'h7F, 8'h01, 1'b0, 1'b0);
        do_op("dffff", 8'hFF, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        do_op("s0507", 8'h05, 8'h07, 1'b0, 1'b1);
        do_op("s8001", 8'h80, 8'h01, 1'b1, 1'b1);
`endif
        for (int i = 0; i < 30; i++)
            do_op("rnd", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        // start re-pulsed mid-run is ignored
        e1 = model(8'h12, 8'h34, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b1; sub = 1'b0; start = 1'b1;
        acc = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'hE7; b = 8'h9C; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(d1, ok1);
        if (ok1) begin
            chk("rep_lat", 64'(d1.edge_n - acc), 64'(LAT));
            check_result("rep", d1, e1);
        end
        repeat (12) @(negedge clk);
        chk("rep_one_done", 64'(done_q.size()), 64'd0);

        // reset at the 4th RUN edge aborts the operation
        @(negedge clk);
        a = 8'h21; b = 8'h43; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (12) @(negedge clk);
        chk("abort_no_done", 64'(done_q.size()), 64'd0);
        done_q.delete();
        prev_sum = '0;
        do_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0);

        // start held across the done cycle: back-to-back operations
        e1 = model(8'h3C, 8'h5A, 1'b0, 1'b0);
        e2 = model(8'hA5, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'h3C; b = 8'h5A; cin = 1'b0; sub = 1'b0; start = 1'b1;
        acc = edge_cnt + 1;
        @(negedge clk);
        a = 8'hA5; b = 8'h0F; cin = 1'b1;
        repeat (LAT) @(negedge clk);
        start = 1'b0;
        wait_done(d1, ok1);
        wait_done(d2, ok2);
        if (ok1 && ok2) begin
            chk("b2b_lat1", 64'(d1.edge_n - acc), 64'(LAT));
            chk("b2b_gap",  64'(d2.edge_n - d1.edge_n), 64'(LAT));
            check_result("b2b1", d1, e1);
            check_result("b2b2", d2, e2);
        end
        repeat (12) @(negedge clk);
        chk("b2b_only_two", 64'(done_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..64.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
REQ-005 Port a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 Port b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 Port cin  input  1  carry-in; captured on the accepting edge.
REQ-008 Port sub  input  1  mode select, 1 = subtract; captured on the accepting edge; ignored when the REQ-026 macro is undefined.
REQ-009 Port busy  output  1  high while in RUN.
REQ-010 Port done  output  1  single-cycle pulse; result valid.
REQ-011 Port sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-012 Port cout  output  1  carry out of the MSB; held with sum.
REQ-013 Port ovf  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB; held with sum.

Function
REQ-014 One 1-bit full-adder cell SHALL process one bit per cycle, LSB first; no WIDTH-wide carry chain.
REQ-015 FSM states SHALL be IDLE, RUN, and DONE.
- IDLE->RUN on start.
- RUN->DONE after WIDTH bit-cycles.
- DONE->RUN on start, otherwise DONE->IDLE.
REQ-016 Accepting edge SHALL load the A/B shift registers, carry flop := cin, bit counter := 0, and enter RUN.
REQ-017 Each RUN edge SHALL compute s = a0^b0^c and c' = a0&b0 | c&(a0^b0), shift s into the MSB of the result register, and shift the operands right.
REQ-018 Latency: done SHALL be high for exactly the cycle following the WIDTH-th RUN edge, which is WIDTH+1 edges after the accepting edge.
REQ-019 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap before reaching WIDTH.
REQ-020 start while in RUN SHALL be ignored, with no queueing and no operand corruption.
REQ-021 start during the done cycle SHALL be accepted (back-to-back); done and the held results remain valid for that cycle.
REQ-022 sum/cout/ovf SHALL update only on the transition into DONE; intermediate bits are not visible on sum.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; cout = bit WIDTH of a+b+cin.

Reset
REQ-024 When rst_n=0 at a rising edge, state := IDLE, busy := 0, done := 0, sum := 0, cout := 0, ovf := 0, counter := 0, carry := 0.
REQ-025 Reset SHALL override all activity.
- Reset during RUN aborts the operation with no done pulse.
- start is ignored on any edge where rst_n=0.

Configuration
REQ-026 Macro SERIAL_ADDER_SUB_EN, when defined: sub=1 at the accepting edge SHALL load ~b, force carry := 1 (cin ignored), and yield sum = a-b mod 2^WIDTH; cout=1 means no borrow.
REQ-027 Macro SERIAL_ADDER_SUB_EN, when undefined:
- The sub port remains present but is ignored.
- Operation is always a+b+cin.
- No inversion logic is synthesised.

Verification (WIDTH=8)
REQ-028 a=0x0F, b=0x01, cin=0 -> done 9 edges after the accepting edge; sum=0x10, cout=0, ovf=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-030 With SERIAL_ADDER_SUB_EN defined, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
REQ-031 start re-pulsed 3 cycles into RUN with different operands -> result still matches the original operands; exactly one done pulse.
REQ-032 rst_n=0 for one edge at the 4th RUN cycle -> busy=0, sum=0, no done pulse; a subsequent start of 0x01+0x01 -> sum=0x02.
REQ-033 start held high across the done cycle -> two consecutive operations, done pulses 9 edges apart, and the second result is correct.
